peri_write_responder: RTL and testbench

Responder for the decode stage's peripheral write port (`peri_web`/`peri_addr`/`peri_datao`). It decodes peripheral writes into a small control/status map, buffers data words in a DEPTH-entry FIFO, and drains them to a downstream sink over a valid/ready handshake. It sits beside the pipeline on the same clock and absorbs at most one peripheral write per cycle without stalling the core.

---
 rtl/peri_write_responder.sv | 119 +++++++++++
 tb/tb_peri_write_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/peri_write_responder.sv
// Peripheral write responder: decodes the decode-stage write port into a DATA/CTRL/CLR map,
// queues DATA words in a small FIFO and presents them to a sink over valid/ready.
module peri_write_responder #(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] ADDR_DATA = 16'h0000,
    parameter logic [15:0] ADDR_CTRL = 16'h0001,
    parameter logic [15:0] ADDR_CLR  = 16'h0002,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          peri_web,
    input  logic [15:0]   peri_addr,
    input  logic [15:0]   peri_datao,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic          drain_en,
    output logic [AW:0]   fifo_count,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          overflow
);

    // state     | meaning
    // S_IDLE    | nothing presented to the sink
    // S_PRESENT | FIFO head driven with out_valid=1, waiting for out_ready
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic [0:0]    state, state_nxt;

    logic wr_en, wr_data, wr_ctrl, wr_clr;
    logic pop, push, drop;

    assign wr_en   = !peri_web;
    assign wr_data = wr_en && (peri_addr == ADDR_DATA);
    assign wr_ctrl = wr_en && (peri_addr == ADDR_CTRL);
    assign wr_clr  = wr_en && (peri_addr == ADDR_CLR);

    // A flush voids a same-cycle handshake; a full FIFO still takes a word if the head leaves.
    assign pop  = (state == S_PRESENT) && out_ready && !wr_clr;
    assign push = wr_data && ((count != FULL_CNT) || pop);
    assign drop = wr_data && !push;

    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_nxt = state;
        if (wr_clr) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (drain_en && ((count != '0) || push))
                        state_nxt = S_PRESENT;
                end
                S_PRESENT: begin
                    if (pop && !(drain_en && (count_nxt != '0)))
                        state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= S_IDLE;
        end else if (wr_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= S_IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            state <= state_nxt;
        end
    end

    // Storage is reset so out_data reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= peri_datao;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_en <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_ctrl) drain_en <= peri_datao[0];
            if (drop)
                overflow <= 1'b1;
            else if (wr_ctrl && peri_datao[1])
                overflow <= 1'b0;
        end
    end

    assign out_valid  = (state == S_PRESENT);
    assign out_data   = mem[rd_ptr];
    assign fifo_count = count;
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

endmodule

// File: tb/tb_peri_write_responder.sv
// Bench for peri_write_responder: per-cycle vector table with expected status outputs,
// plus a scoreboard queue of words the sink should receive in order.
module tb_peri_write_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        peri_web = 1'b1;
    logic [15:0] peri_addr = 16'h00FF;
    logic [15:0] peri_datao = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        drain_en;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;

    peri_write_responder dut (
        .clk        (clk),
        .rst        (rst),
        .peri_web   (peri_web),
        .peri_addr  (peri_addr),
        .peri_datao (peri_datao),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drain_en   (drain_en),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] A_DATA = 16'h0000;
    localparam logic [15:0] A_CTRL = 16'h0001;
    localparam logic [15:0] A_CLR  = 16'h0002;
    localparam logic [15:0] A_NONE = 16'h00FF;

    typedef struct {
        logic        web;
        logic [15:0] addr;
        logic [15:0] data;
        logic        ready;
        logic        push;   // word expected to be accepted into the FIFO
        logic        ev;     // expected out_valid after the edge
        logic [2:0]  ec;     // expected fifo_count
        logic        eo;     // expected overflow
        logic        ed;     // expected drain_en
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sb_q[$];
    int          n_vec = 0;
    int          n_miscmp = 0;

    function automatic vec_t mk(logic web, logic [15:0] addr, logic [15:0] data, logic ready,
                                logic push, logic ev, logic [2:0] ec, logic eo, logic ed);
        vec_t t;
        t.web = web; t.addr = addr; t.data = data; t.ready = ready; t.push = push;
        t.ev = ev; t.ec = ec; t.eo = eo; t.ed = ed;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive, score any handshake, clock once, check at the next falling edge.
    task automatic run_vec(input vec_t t, input int idx);
        logic [15:0] exp_w;
        peri_web   = t.web;
        peri_addr  = t.addr;
        peri_datao = t.data;
        out_ready  = t.ready;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk($sformatf("v%0d_unexpected_pop", idx), 32'(out_data), 32'hDEAD_BEEF);
            end else begin
                exp_w = sb_q.pop_front();
                chk($sformatf("v%0d_sink_data", idx), 32'(out_data), 32'(exp_w));
            end
        end
        if (t.push) sb_q.push_back(t.data);
        if (!t.web && t.addr == A_CLR) sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_valid", idx), 32'(out_valid), 32'(t.ev));
        chk($sformatf("v%0d_count", idx), 32'(fifo_count), 32'(t.ec));
        chk($sformatf("v%0d_full", idx), 32'(fifo_full), 32'(t.ec == 3'd4));
        chk($sformatf("v%0d_empty", idx), 32'(fifo_empty), 32'(t.ec == 3'd0));
        chk($sformatf("v%0d_overflow", idx), 32'(overflow), 32'(t.eo));
        chk($sformatf("v%0d_drain", idx), 32'(drain_en), 32'(t.ed));
        if (out_valid && sb_q.size() > 0)
            chk($sformatf("v%0d_head", idx), 32'(out_data), 32'(sb_q[0]));
    endtask

    initial begin
        // web  addr    data      rdy push  ev  cnt ovf drn
        // present a single word
        tbl.push_back(mk(0, A_CTRL, 16'h0001, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, A_DATA, 16'hA5A5, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(1, A_NONE, 16'h0000, 1, 0, 0, 0, 0, 1));
        // fill to full with drain off, fifth word dropped, then burst drain
        tbl.push_back(mk(0, A_CTRL, 16'h0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, A_DATA, 16'h0001, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, A_DATA, 16'h0002, 0, 1, 0, 2, 0, 0));
        tbl.push_back(mk(0, A_DATA, 16'h0003, 0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(0, A_DATA, 16'h0004, 0, 1, 0, 4, 0, 0));
        tbl.push_back(mk(0, A_DATA, 16'h0005, 0, 0, 0, 4, 1, 0));
        tbl.push_back(mk(0, A_CTRL, 16'h0001, 1, 0, 0, 4, 1, 1));
        tbl.push_back(mk(1, A_NONE, 16'h0000, 1, 0, 1, 4, 1, 1));
        tbl.push_back(mk(1, A_NONE, 16'h0000, 1, 0, 1, 3, 1, 1));
        tbl.push_back(mk(1, A_NONE, 16'h0000, 1, 0, 1, 2, 1, 1));
        tbl.push_back(mk(1, A_NONE, 16'h0000, 1, 0, 1, 1, 1, 1));
        tbl.push_back(mk(1, A_NONE, 16'h0000, 1, 0, 0, 0, 1, 1));
        // clear overflow, refill while presenting, push into full FIFO during a pop
        tbl.push_back(mk(0, A_CTRL, 16'h0003, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, A_DATA, 16'h0010, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, A_DATA, 16'h0011, 0, 1, 1, 2, 0, 1));
        tbl.push_back(mk(0, A_DATA, 16'h0012, 0, 1, 1, 3, 0, 1));
        tbl.push_back(mk(0, A_DATA, 16'h0013, 0, 1, 1, 4, 0, 1));
        tbl.push_back(mk(0, A_DATA, 16'h0014, 1, 1, 1, 4, 0, 1));
        // drain_en dropped while presenting: word held until accepted, then idle
        tbl.push_back(mk(0, A_CTRL, 16'h0000, 0, 0, 1, 4, 0, 0));
        tbl.push_back(mk(1, A_NONE, 16'h0000, 0, 0, 1, 4, 0, 0));
        tbl.push_back(mk(1, A_NONE, 16'h0000, 1, 0, 0, 3, 0, 0));
        tbl.push_back(mk(1, A_NONE, 16'h0000, 1, 0, 0, 3, 0, 0));
        // flush in the same cycle as a handshake
        tbl.push_back(mk(0, A_CTRL, 16'h0001, 0, 0, 0, 3, 0, 1));
        tbl.push_back(mk(1, A_NONE, 16'h0000, 0, 0, 1, 3, 0, 1));
        tbl.push_back(mk(0, A_CLR,  16'hFFFF, 1, 0, 0, 0, 0, 1));
        // overflow survives a flush, then cleared via CTRL bit1
        tbl.push_back(mk(0, A_CTRL, 16'h0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, A_DATA, 16'h0020, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, A_DATA, 16'h0021, 0, 1, 0, 2, 0, 0));
        tbl.push_back(mk(0, A_DATA, 16'h0022, 0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(0, A_DATA, 16'h0023, 0, 1, 0, 4, 0, 0));
        tbl.push_back(mk(0, A_DATA, 16'h0024, 0, 0, 0, 4, 1, 0));
        tbl.push_back(mk(0, A_CLR,  16'h0000, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, A_CTRL, 16'h0002, 0, 0, 0, 0, 0, 0));
        // unmapped address and writes with the strobe inactive
        tbl.push_back(mk(0, A_NONE, 16'hFFFF, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, A_DATA, 16'h1234, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, A_CTRL, 16'h0001, 0, 0, 0, 0, 0, 0));
        // flush withdraws out_valid while drain stays enabled
        tbl.push_back(mk(0, A_CTRL, 16'h0001, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, A_DATA, 16'h0055, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, A_CLR,  16'h0000, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, A_NONE, 16'h0000, 0, 0, 0, 0, 0, 1));
        // word in flight for the async reset check
        tbl.push_back(mk(0, A_DATA, 16'h0077, 0, 1, 1, 1, 0, 1));

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drain", 32'(drain_en), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // async reset mid-transfer: out_valid must fall without a clock edge
        peri_web  = 1'b1;
        peri_addr = A_NONE;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_drain", 32'(drain_en), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_arst_empty", 32'(fifo_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
